// File: rtl/pow_k_pipe_stall.sv
// n^EXP in an (EXP-1)-stage multiplier pipeline with valid/ready on both sides.
// A stalled last stage freezes the whole pipe; overflow is sticky along the stages.
module pow_k_pipe_stall #(
  parameter int W     = 18,
  parameter int EXP   = 5,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     n,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             overflow,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NS = EXP - 1;

  logic [NS-1:0]    vld_q, vld_d;
  logic [NS-1:0]    ovf_q, ovf_d;
  logic [W-1:0]     n_q    [NS];
  logic [W-1:0]     n_d    [NS];
  logic [W-1:0]     part_q [NS];
  logic [W-1:0]     part_d [NS];
  logic [TAG_W-1:0] tag_q  [NS];
  logic [TAG_W-1:0] tag_d  [NS];
  logic [2*W-1:0]   prod_s [NS];
  logic             advance_s;

  // Full-width product feeding each stage; upper half flags overflow.
  always_comb begin
    prod_s[0] = (2*W)'(n) * (2*W)'(n);
    for (int k = 1; k < NS; k++) begin
      prod_s[k] = (2*W)'(part_q[k-1]) * (2*W)'(n_q[k-1]);
    end
  end

  assign advance_s = !(vld_q[NS-1] && !out_ready);
  assign in_ready  = advance_s;

  // Next-state: shift every stage on advance, otherwise hold everything.
  always_comb begin
    vld_d  = vld_q;
    ovf_d  = ovf_q;
    n_d    = n_q;
    part_d = part_q;
    tag_d  = tag_q;
    if (advance_s) begin
      vld_d[0]  = in_valid;
      n_d[0]    = n;
      part_d[0] = prod_s[0][W-1:0];
      ovf_d[0]  = |prod_s[0][2*W-1:W];
      tag_d[0]  = in_tag;
      for (int k = 1; k < NS; k++) begin
        vld_d[k]  = vld_q[k-1];
        n_d[k]    = n_q[k-1];
        part_d[k] = prod_s[k][W-1:0];
        ovf_d[k]  = ovf_q[k-1] | (|prod_s[k][2*W-1:W]);
        tag_d[k]  = tag_q[k-1];
      end
    end else begin
      vld_d  = vld_q;
      ovf_d  = ovf_q;
      n_d    = n_q;
      part_d = part_q;
      tag_d  = tag_q;
    end
  end

  // Stage registers; reset drops all in-flight operands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= {NS{1'b0}};
      ovf_q <= {NS{1'b0}};
      for (int k = 0; k < NS; k++) begin
        n_q[k]    <= {W{1'b0}};
        part_q[k] <= {W{1'b0}};
        tag_q[k]  <= {TAG_W{1'b0}};
      end
    end else begin
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      n_q    <= n_d;
      part_q <= part_d;
      tag_q  <= tag_d;
    end
  end

  assign out_valid = vld_q[NS-1];
  assign result    = part_q[NS-1];
  assign overflow  = ovf_q[NS-1];
  assign out_tag   = tag_q[NS-1];

endmodule

// File: tb/tb_pow_k_pipe_stall.sv
// Scoreboard bench for pow_k_pipe_stall: table vectors, random backpressure,
// sparse input, mid-flight reset, and a small EXP=2/W=8 instance.
module tb_pow_k_pipe_stall;

  localparam int W = 18;
  localparam int EXP = 5;
  localparam int TAG_W = 4;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     n;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             overflow;
  logic [TAG_W-1:0] out_tag;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, overflow2;
  logic [7:0] n2, result2;
  logic       in_tag2, out_tag2;

  pow_k_pipe_stall #(.W(W), .EXP(EXP), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .out_tag(out_tag)
  );

  pow_k_pipe_stall #(.W(8), .EXP(2), .TAG_W(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .n(n2), .in_tag(in_tag2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .overflow(overflow2), .out_tag(out_tag2)
  );

  typedef struct {
    logic [W-1:0]     n;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     res;
    logic             ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0]     res;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               lat;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit   lat_chk = 1'b0;
  logic [W-1:0] exp_res;
  logic         exp_ovf;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model(input longint nv, input int e, input int w,
                                output logic [63:0] r, output logic o);
    longint lim, t, m;
    lim = longint'(64'd1 << w);
    t = 1;
    m = 1;
    o = 1'b0;
    for (int i = 0; i < e; i++) begin
      m = (m * nv) % lim;
      if (!o) begin
        t = t * nv;
        if (t >= lim) o = 1'b1;
      end
    end
    r = 64'(m);
  endfunction

  // Monitor: scoreboard push/pop, in_ready rule and stall stability.
  initial begin
    logic             prev_stall;
    logic [W-1:0]     prev_res;
    logic             prev_ovf;
    logic [TAG_W-1:0] prev_tag;
    sb_t              e;
    prev_stall = 1'b0;
    prev_res = '0;
    prev_ovf = 1'b0;
    prev_tag = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_result", 64'(result), 64'(prev_res));
          check("stall_ovf", 64'(overflow), 64'(prev_ovf));
          check("stall_tag", 64'(out_tag), 64'(prev_tag));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_output act=result%0d req=no_output t=%0t", result, $time);
          end else begin
            e = sb.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("overflow", 64'(overflow), 64'(e.ovf));
            check("out_tag", 64'(out_tag), 64'(e.tag));
            if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(EXP - 1));
          end
        end
        if (in_valid && in_ready) begin
          e.res = exp_res;
          e.ovf = exp_ovf;
          e.tag = in_tag;
          e.cyc = cyc;
          e.lat = lat_chk;
          sb.push_back(e);
        end
        prev_stall = out_valid && !out_ready;
        prev_res = result;
        prev_ovf = overflow;
        prev_tag = out_tag;
      end
    end
  end

  task automatic send(input logic [W-1:0] nv, input logic [TAG_W-1:0] tv,
                      input logic [W-1:0] er, input logic eo);
    int  guard;
    bit  acc;
    guard = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    n = nv;
    in_tag = tv;
    exp_res = er;
    exp_ovf = eo;
    while (!acc && guard < 500) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      guard++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout act=not_accepted req=accepted n=%0d", nv);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [W-1:0] nv, input logic [TAG_W-1:0] tv);
    logic [63:0] r;
    logic        o;
    model(longint'(nv), EXP, W, r, o);
    send(nv, tv, r[W-1:0], o);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 400) begin
      @(posedge clock);
      #1;
      g++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout act=%0d_pending req=0_pending", sb.size());
    end
  endtask

  vec_t tbl[12];

  initial begin
    int g;
    tbl[0]  = '{18'd0,      4'd0,  18'd0,      1'b0};
    tbl[1]  = '{18'd1,      4'd1,  18'd1,      1'b0};
    tbl[2]  = '{18'd2,      4'd2,  18'd32,     1'b0};
    tbl[3]  = '{18'd3,      4'd3,  18'd243,    1'b0};
    tbl[4]  = '{18'd4,      4'd4,  18'd1024,   1'b0};
    tbl[5]  = '{18'd5,      4'd5,  18'd3125,   1'b0};
    tbl[6]  = '{18'd6,      4'd6,  18'd7776,   1'b0};
    tbl[7]  = '{18'd7,      4'd7,  18'd16807,  1'b0};
    tbl[8]  = '{18'd12,     4'd8,  18'd248832, 1'b0};
    tbl[9]  = '{18'd13,     4'd9,  18'd109149, 1'b1};
    tbl[10] = '{18'd255,    4'd10, 18'd132351, 1'b1};
    tbl[11] = '{18'd131072, 4'd11, 18'd0,      1'b1};

    reset_n = 1'b0;
    in_valid = 1'b0;
    n = '0;
    in_tag = '0;
    exp_res = '0;
    exp_ovf = 1'b0;
    out_ready = 1'b1;
    in_valid2 = 1'b0;
    n2 = 8'd0;
    in_tag2 = 1'b0;
    out_ready2 = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Table vectors back-to-back, no backpressure.
    rdy_mode = 0;
    lat_chk = 1'b1;
    idle(1);
    for (int i = 0; i < 12; i++) send(tbl[i].n, tbl[i].tag, tbl[i].res, tbl[i].ovf);
    drain();

    // Random backpressure stream.
    lat_chk = 1'b0;
    rdy_mode = 1;
    idle(1);
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 3) send_model(W'($urandom_range(0, 262143)), TAG_W'(i));
      else            send_model(W'($urandom_range(0, 40)), TAG_W'(i));
    end
    drain();

    // Sparse input, bubbles preserved, fixed latency.
    rdy_mode = 0;
    idle(2);
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_model(W'(i + 8), TAG_W'(15 - i));
      idle(2);
    end
    drain();

    // Mid-flight reset with a stalled result at the output.
    lat_chk = 1'b0;
    rdy_mode = 2;
    idle(1);
    send_model(18'd2, 4'd1);
    send_model(18'd3, 4'd2);
    send_model(18'd4, 4'd3);
    g = 0;
    @(negedge clock);
    while (!out_valid && g < 20) begin
      @(negedge clock);
      g++;
    end
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_result", 64'(result), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(8);
    lat_chk = 1'b1;
    send(18'd3, 4'd5, 18'd243, 1'b0);
    drain();

    // EXP=2, W=8 instance: latency 1.
    @(posedge clock);
    #1;
    in_valid2 = 1'b1;
    n2 = 8'd15;
    in_tag2 = 1'b1;
    @(posedge clock);
    #1;
    n2 = 8'd16;
    in_tag2 = 1'b0;
    @(negedge clock);
    check("e2_valid_a", 64'(out_valid2), 64'd1);
    check("e2_result_a", 64'(result2), 64'd225);
    check("e2_ovf_a", 64'(overflow2), 64'd0);
    check("e2_tag_a", 64'(out_tag2), 64'd1);
    @(posedge clock);
    #1;
    in_valid2 = 1'b0;
    @(negedge clock);
    check("e2_valid_b", 64'(out_valid2), 64'd1);
    check("e2_result_b", 64'(result2), 64'd0);
    check("e2_ovf_b", 64'(overflow2), 64'd1);
    check("e2_tag_b", 64'(out_tag2), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check("e2_valid_c", 64'(out_valid2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
